hex_dump_tx: RTL and testbench

//  Downstream of the CPU write decoder's UART data register. Buffers bytes the CPU

---
 rtl/hex_dump_tx.sv | 144 ++++++++++++++
 tb/tb_hex_dump_tx.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hex_dump_tx.sv
// Buffers CPU-written bytes in a FIFO and streams them to the UART as uppercase hex text lines.
// Define HEX_DUMP_FLUSH_EN to close a partial line after FLUSH_CYCLES idle cycles.
module hex_dump_tx #(
  parameter int DEPTH_LOG2     = 4,
  parameter int BYTES_PER_LINE = 16,
  parameter int FLUSH_CYCLES   = 480000
) (
  input  logic       clk_48mhz,
  input  logic       internal_rst,
  input  logic [7:0] wr_data,
  input  logic       wr_stb,
  output logic       full,
  output logic       overflow,
  output logic [7:0] txin,
  output logic       txrdy,
  input  logic       txactive,
  output logic       idle
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [7:0] LINE_LEN = 8'(BYTES_PER_LINE);

  if (BYTES_PER_LINE < 1 || BYTES_PER_LINE > 255 || FLUSH_CYCLES < 1) begin : g_param_check
    $error("hex_dump_tx: parameter out of range");
  end

  typedef enum logic [2:0] {IDLE, HI, LO, SEP, CR, LF, GUARD} state_t;

  state_t                state, state_nx, ret, ret_nx, send_ret;
  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0]   count, count_nx;
  logic [7:0]            cur, cur_nx, col, col_nx, txin_nx, send_char;
  logic                  txrdy_nx, push, pop, send, flush_hit;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

`ifdef HEX_DUMP_FLUSH_EN
  localparam int FW = $clog2(FLUSH_CYCLES + 1);
  logic [FW-1:0] flush_cnt;
  logic          line_open;

  assign line_open = (state == IDLE) && (count == '0) && (col != '0);
  assign flush_hit = line_open && !push && (flush_cnt == FW'(FLUSH_CYCLES));

  always_ff @(posedge clk_48mhz) begin
    if (internal_rst || push || !line_open || flush_hit) flush_cnt <= '0;
    else                                                 flush_cnt <= flush_cnt + FW'(1);
  end
`else
  assign flush_hit = 1'b0;
`endif

  always_comb begin
    push      = wr_stb && !full;
    pop       = 1'b0;
    state_nx  = state;
    ret_nx    = ret;
    cur_nx    = cur;
    col_nx    = col;
    txin_nx   = txin;
    txrdy_nx  = 1'b0;
    send      = 1'b0;
    send_char = 8'h20;
    send_ret  = IDLE;

    case (state)
      IDLE: begin
        if (count != '0) begin
          pop      = 1'b1;
          cur_nx   = mem[rd_ptr];
          state_nx = HI;
        end else if (flush_hit) begin
          state_nx = CR;
        end
      end
      HI:  begin send = 1'b1; send_char = hex_char(cur[7:4]); send_ret = LO; end
      LO:  begin
        send      = 1'b1;
        send_char = hex_char(cur[3:0]);
        send_ret  = ((col + 8'd1) == LINE_LEN) ? CR : SEP;
      end
      SEP: begin send = 1'b1; send_char = 8'h20; send_ret = IDLE; end
      CR:  begin send = 1'b1; send_char = 8'h0D; send_ret = LF;   end
      LF:  begin send = 1'b1; send_char = 8'h0A; send_ret = IDLE; end
      GUARD:   state_nx = ret;
      default: state_nx = IDLE;
    endcase

    // Every character goes out through GUARD, which returns to the state queued in ret.
    if (send && !txactive) begin
      txin_nx  = send_char;
      txrdy_nx = 1'b1;
      ret_nx   = send_ret;
      state_nx = GUARD;
      if (state == LO) col_nx = col + 8'd1;
      if (state == LF) col_nx = '0;
    end

    case ({push, pop})
      2'b10:   count_nx = count + (DEPTH_LOG2 + 1)'(1);
      2'b01:   count_nx = count - (DEPTH_LOG2 + 1)'(1);
      default: count_nx = count;
    endcase
  end

  always_ff @(posedge clk_48mhz) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk_48mhz) begin
    if (internal_rst) begin
      state    <= IDLE;
      ret      <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      overflow <= 1'b0;
      cur      <= '0;
      col      <= '0;
      txin     <= '0;
      txrdy    <= 1'b0;
      idle     <= 1'b1;
    end else begin
      state    <= state_nx;
      ret      <= ret_nx;
      count    <= count_nx;
      full     <= (count_nx == FULL_COUNT);
      cur      <= cur_nx;
      col      <= col_nx;
      txin     <= txin_nx;
      txrdy    <= txrdy_nx;
      idle     <= (count_nx == '0) && (state_nx == IDLE);
      if (push)             wr_ptr   <= wr_ptr + DEPTH_LOG2'(1);
      if (pop)              rd_ptr   <= rd_ptr + DEPTH_LOG2'(1);
      if (wr_stb && full)   overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_hex_dump_tx.sv
// Bench for hex_dump_tx: randomized bytes and UART busy times against a text-stream reference model.
module tb_hex_dump_tx;

  localparam int BPL = 16;

  logic       clk_48mhz = 1'b0;
  logic       internal_rst;
  logic [7:0] wr_data;
  logic       wr_stb;
  logic       full, overflow, txrdy, txactive, idle;
  logic [7:0] txin;

  always #5 clk_48mhz = ~clk_48mhz;

  hex_dump_tx #(.DEPTH_LOG2(4), .BYTES_PER_LINE(BPL), .FLUSH_CYCLES(100)) dut (
    .clk_48mhz(clk_48mhz), .internal_rst(internal_rst), .wr_data(wr_data), .wr_stb(wr_stb),
    .full(full), .overflow(overflow), .txin(txin), .txrdy(txrdy), .txactive(txactive), .idle(idle)
  );

  int         errors = 0;
  int         checks = 0;
  logic [7:0] rx[$];
  logic [7:0] expq[$];
  int         busy_len = 0;
  int         busy_cnt = 0;
  logic       force_busy = 1'b0;
  logic       prev_txrdy = 1'b0;
  int         col_m = 0;

  assign txactive = force_busy || (busy_cnt != 0);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // UART model: captures each started character and stays busy busy_len cycles.
  always @(posedge clk_48mhz) begin
    #1;
    if (txrdy === 1'b1) begin
      check("txrdy_single_cycle", prev_txrdy, 0);
      rx.push_back(txin);
      busy_cnt <= busy_len;
    end else if (busy_cnt > 0) begin
      busy_cnt <= busy_cnt - 1;
    end
    prev_txrdy <= txrdy;
  end

  function automatic logic [7:0] hexc(input int n);
    return (n < 10) ? 8'(48 + n) : 8'(65 + n - 10);
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    expq.push_back(hexc(int'(b) / 16));
    expq.push_back(hexc(int'(b) % 16));
    col_m++;
    if (col_m == BPL) begin
      expq.push_back(8'h0D);
      expq.push_back(8'h0A);
      col_m = 0;
    end else begin
      expq.push_back(8'h20);
    end
  endfunction

  task automatic write_byte(input logic [7:0] b);
    wr_data = b;
    wr_stb  = 1'b1;
    @(negedge clk_48mhz);
    wr_stb  = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk_48mhz);
  endtask

  task automatic wait_rx(input int target, input string tag);
    int t = 0;
    while (rx.size() < target && t < 20000) begin
      @(negedge clk_48mhz);
      t++;
    end
    check({tag, "_wait"}, 32'(rx.size() >= target), 1);
  endtask

  task automatic check_stream(input string tag);
    wait_rx(expq.size(), tag);
    idle_cycles(4);
    check({tag, "_len"}, rx.size(), expq.size());
    for (int i = 0; i < expq.size() && i < rx.size(); i++)
      check($sformatf("%s_ch%0d", tag, i), rx[i], expq[i]);
    check({tag, "_idle"}, idle, 1);
    rx.delete();
    expq.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    int         tgt0;
    int         n;

    internal_rst = 1'b1;
    wr_stb       = 1'b0;
    wr_data      = '0;
    repeat (3) @(posedge clk_48mhz);
    #1;
    check("rst_txrdy", txrdy, 0);
    check("rst_txin", txin, 8'h00);
    check("rst_full", full, 0);
    check("rst_overflow", overflow, 0);
    check("rst_idle", idle, 1);
    @(negedge clk_48mhz);
    internal_rst = 1'b0;

    // Full line 00..0F ends with CR LF.
    busy_len = 0;
    for (int i = 0; i < 16; i++) begin
      model_byte(8'(i));
      write_byte(8'(i));
    end
    check_stream("line16");

    // Single byte A5 with a slow UART, plus strobe-to-txrdy latency.
    busy_len = 10;
    model_byte(8'hA5);
    wr_data = 8'hA5;
    wr_stb  = 1'b1;
    @(posedge clk_48mhz); #1;
    wr_stb  = 1'b0;
    @(posedge clk_48mhz); #1;
    check("lat_cycle1_txrdy", txrdy, 0);
    @(posedge clk_48mhz); #1;
    check("lat_cycle2_txrdy", txrdy, 1);
    check("lat_cycle2_txin", txin, 8'h41);
    @(negedge clk_48mhz);
    check_stream("a5");

    // UART held busy: one byte parked in the FSM, sixteen fill the FIFO, the next is dropped.
    busy_len   = 0;
    force_busy = 1'b1;
    b = 8'($urandom);
    model_byte(b);
    write_byte(b);
    idle_cycles(3);
    for (int i = 0; i < 16; i++) begin
      b = 8'($urandom);
      model_byte(b);
      write_byte(b);
      if (i == 14) check("ovf_full_at15", full, 0);
    end
    check("ovf_full_at16", full, 1);
    check("ovf_before_drop", overflow, 0);
    write_byte(8'($urandom));
    check("ovf_after_drop", overflow, 1);
    check("ovf_full_after_drop", full, 1);
    force_busy = 1'b0;
    check_stream("ovf");
    check("ovf_full_drained", full, 0);
    check("ovf_sticky", overflow, 1);

    // Push coinciding with pop while three bytes are queued.
    force_busy = 1'b1;
    b = 8'($urandom);
    model_byte(b);
    tgt0 = expq.size();
    write_byte(b);
    for (int i = 0; i < 3; i++) begin
      b = 8'($urandom);
      model_byte(b);
      write_byte(b);
    end
    force_busy = 1'b0;
    wait_rx(tgt0, "pp_first");
    @(negedge clk_48mhz);
    force_busy = 1'b1;
    b = 8'($urandom);
    model_byte(b);
    write_byte(b);
    for (int i = 0; i < 13; i++) begin
      b = 8'($urandom);
      model_byte(b);
      write_byte(b);
      if (i == 11) check("pp_full_at15", full, 0);
    end
    check("pp_full_at16", full, 1);
    force_busy = 1'b0;
    check_stream("pushpop");

    // Random bursts with random UART busy times and write gaps.
    for (int r = 0; r < 5; r++) begin
      busy_len = $urandom_range(0, 5);
      n = $urandom_range(1, 16);
      for (int k = 0; k < n; k++) begin
        b = 8'($urandom);
        model_byte(b);
        write_byte(b);
        if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 3));
      end
      check_stream($sformatf("burst%0d", r));
    end

    // Reset while the low digit of 3C waits on a busy UART.
    busy_len = 10;
    expq.push_back(8'h33);
    write_byte(8'h3C);
    wait_rx(1, "rst_mid_hi");
    @(negedge clk_48mhz);
    internal_rst = 1'b1;
    @(posedge clk_48mhz); #1;
    check("rstmid_txrdy", txrdy, 0);
    check("rstmid_idle", idle, 1);
    check("rstmid_overflow", overflow, 0);
    check("rstmid_full", full, 0);
    @(negedge clk_48mhz);
    internal_rst = 1'b0;
    col_m = 0;
    check_stream("rst_mid");
    model_byte(8'h01);
    write_byte(8'h01);
    check_stream("after_rst");

    // Partial line left idle: auto flush only when the feature is built.
    busy_len = 2;
    model_byte(8'h7E);
    write_byte(8'h7E);
`ifdef HEX_DUMP_FLUSH_EN
    expq.push_back(8'h0D);
    expq.push_back(8'h0A);
    col_m = 0;
`endif
    wait_rx(3, "flush_bytes");
    idle_cycles(50);
    check("flush_not_early", rx.size(), 3);
    idle_cycles(200);
    check_stream("flush");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
